// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared definitions for the SERDES transmit framer: 9-bit {k,byte} K-code
// symbols, the framer state encoding and the CRC-16-CCITT constants.
// No ports (package).
// -----------------------------------------------------------------------------
package serdes_pkg;

   // K-codes as {k, byte} ready for the 8b/10b encoder datain[8:0]
   localparam logic [8:0] K28_5 = 9'h1BC;   // idle / fill
   localparam logic [8:0] K27_7 = 9'h1FB;   // start of frame
   localparam logic [8:0] K29_7 = 9'h1FD;   // end of frame
   localparam logic [8:0] K30_7 = 9'h1FE;   // frame aborted

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DATA   = 3'd1,
      CRC_HI = 3'd2,
      CRC_LO = 3'd3,
      EOP    = 3'd4,
      IFG    = 3'd5
   } state_e;

endpackage

// File: rtl/crc16_ccitt_8.sv
// -----------------------------------------------------------------------------
// crc16_ccitt_8
// Combinational byte-wide next-state function for CRC-16-CCITT
// (poly 0x1021, MSB first, no reflection).
// Ports:
//   crc_in  [15:0] in   current CRC register
//   data    [7:0]  in   byte to fold in
//   crc_out [15:0] out  CRC after the byte
// -----------------------------------------------------------------------------
module crc16_ccitt_8
   import serdes_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   logic [15:0] crc_s;
   logic [7:0]  dat_s;
   logic        fb_s;

   // Serial LFSR unrolled eight times; the data byte is shifted out MSB first
   always_comb begin
      crc_s = crc_in;
      dat_s = data;
      fb_s  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fb_s  = crc_s[15] ^ dat_s[7];
         crc_s = fb_s ? ({crc_s[14:0], 1'b0} ^ CRC_POLY) : {crc_s[14:0], 1'b0};
         dat_s = {dat_s[6:0], 1'b0};
      end
      crc_out = crc_s;
   end

endmodule

// File: rtl/serdes_tx_framer.sv
// -----------------------------------------------------------------------------
// serdes_tx_framer
// Wraps a valid/ready byte stream into K-code delimited frames for the 8b/10b
// encoder: SOP, payload, optional CRC-16, EOP, then a minimum run of idles.
// Any non-frame cycle carries K28.5. An upstream underrun mid-frame emits ABORT.
// Ports:
//   clk, rst            symbol clock, async active-high reset
//   enable              gates the start of new frames only
//   data_i/sop_i/eop_i  payload byte and frame markers, qualified by valid_i
//   valid_i / ready_o   handshake (ready_o is combinational)
//   sym_o   [8:0]       registered {k, byte} symbol to the encoder
//   busy_o              framer not in IDLE
//   frame_cnt_o [15:0]  frames closed with EOP (wraps)
//   abort_cnt_o [15:0]  frames closed with ABORT (wraps)
// -----------------------------------------------------------------------------
module serdes_tx_framer
   import serdes_pkg::*;
#(
   parameter int unsigned MIN_IFG = 2,
   parameter bit          CRC_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [7:0]  data_i,
   input  logic        sop_i,
   input  logic        eop_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [8:0]  sym_o,
   output logic        busy_o,
   output logic [15:0] frame_cnt_o,
   output logic [15:0] abort_cnt_o
);

   // Last gap count value before returning to IDLE
   localparam logic [3:0] IFG_LAST = 4'(MIN_IFG - 1);

   state_e      state_q, state_d;
   logic [8:0]  sym_q,   sym_d;
   logic [15:0] crc_q,   crc_d;
   logic [3:0]  ifg_q,   ifg_d;
   logic [15:0] fcnt_q,  fcnt_d;
   logic [15:0] acnt_q,  acnt_d;
   logic [15:0] crc_next_s;

   crc16_ccitt_8 u_crc (
      .crc_in  (crc_q),
      .data    (data_i),
      .crc_out (crc_next_s)
   );

   // Next-state, next-symbol and handshake decode
   always_comb begin
      state_d = state_q;
      sym_d   = K28_5;
      crc_d   = crc_q;
      ifg_d   = ifg_q;
      fcnt_d  = fcnt_q;
      acnt_d  = acnt_q;
      ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            // Non-SOP words arriving outside a frame are accepted and dropped;
            // an SOP word is left pending and consumed from DATA.
            ready_o = valid_i & ~sop_i;
            if (enable & valid_i & sop_i) begin
               sym_d   = K27_7;
               crc_d   = CRC_INIT;
               state_d = DATA;
            end else begin
               sym_d   = K28_5;
            end
         end
         DATA: begin
            ready_o = 1'b1;
            if (valid_i) begin
               sym_d = {1'b0, data_i};
               crc_d = crc_next_s;
               if (eop_i) begin
                  state_d = CRC_EN ? CRC_HI : EOP;
               end else begin
                  state_d = DATA;
               end
            end else begin
               // Underrun: the line cannot stall mid-frame, so close it as aborted
               sym_d   = K30_7;
               acnt_d  = acnt_q + 16'd1;
               ifg_d   = 4'd0;
               state_d = IFG;
            end
         end
         CRC_HI: begin
            sym_d   = {1'b0, crc_q[15:8]};
            state_d = CRC_LO;
         end
         CRC_LO: begin
            sym_d   = {1'b0, crc_q[7:0]};
            state_d = EOP;
         end
         EOP: begin
            sym_d   = K29_7;
            fcnt_d  = fcnt_q + 16'd1;
            ifg_d   = 4'd0;
            state_d = IFG;
         end
         IFG: begin
            sym_d = K28_5;
            ifg_d = ifg_q + 4'd1;
            if (ifg_q == IFG_LAST) begin
               state_d = IDLE;
            end else begin
               state_d = IFG;
            end
         end
         default: begin
            sym_d   = K28_5;
            state_d = IDLE;
         end
      endcase
   end

   // State, symbol, CRC and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sym_q   <= K28_5;
         crc_q   <= CRC_INIT;
         ifg_q   <= 4'd0;
         fcnt_q  <= 16'd0;
         acnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         sym_q   <= sym_d;
         crc_q   <= crc_d;
         ifg_q   <= ifg_d;
         fcnt_q  <= fcnt_d;
         acnt_q  <= acnt_d;
      end
   end

   assign sym_o       = sym_q;
   assign busy_o      = (state_q != IDLE);
   assign frame_cnt_o = fcnt_q;
   assign abort_cnt_o = acnt_q;

endmodule

// File: tb/tb_serdes_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_serdes_tx_framer
// Two framers (CRC on / CRC off) share one input stream. The source follows the
// handshake of the CRC-on instance; a symbol-schedule model predicts both.
// -----------------------------------------------------------------------------
module tb_serdes_tx_framer;
   import serdes_pkg::*;

   localparam int N     = 2;
   localparam int IFG_N = 2;

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        enable  = 1'b1;
   logic [7:0]  data_i  = 8'h00;
   logic        sop_i   = 1'b0;
   logic        eop_i   = 1'b0;
   logic        valid_i = 1'b0;

   logic        ready_a, ready_b, busy_a, busy_b;
   logic [8:0]  sym_a, sym_b;
   logic [15:0] fcnt_a, fcnt_b, acnt_a, acnt_b;

   always #5 clk = ~clk;

   serdes_tx_framer #(.MIN_IFG(IFG_N), .CRC_EN(1'b1)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .data_i(data_i), .sop_i(sop_i),
      .eop_i(eop_i), .valid_i(valid_i), .ready_o(ready_a), .sym_o(sym_a),
      .busy_o(busy_a), .frame_cnt_o(fcnt_a), .abort_cnt_o(acnt_a));

   serdes_tx_framer #(.MIN_IFG(IFG_N), .CRC_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .data_i(data_i), .sop_i(sop_i),
      .eop_i(eop_i), .valid_i(valid_i), .ready_o(ready_b), .sym_o(sym_b),
      .busy_o(busy_b), .frame_cnt_o(fcnt_b), .abort_cnt_o(acnt_b));

   logic [8:0]  o_sym  [N];
   logic        o_rdy  [N];
   logic        o_busy [N];
   logic [15:0] o_fcnt [N];
   logic [15:0] o_acnt [N];
   assign o_sym[0]  = sym_a;   assign o_sym[1]  = sym_b;
   assign o_rdy[0]  = ready_a; assign o_rdy[1]  = ready_b;
   assign o_busy[0] = busy_a;  assign o_busy[1] = busy_b;
   assign o_fcnt[0] = fcnt_a;  assign o_fcnt[1] = fcnt_b;
   assign o_acnt[0] = acnt_a;  assign o_acnt[1] = acnt_b;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Per instance: the symbol now on the line, a schedule of symbols that are
   // already committed (CRC, EOP, idle gap), whether a frame is open, and the
   // payload collected since SOP.
   logic [8:0]  m_sym  [N];
   logic [15:0] m_fcnt [N];
   logic [15:0] m_acnt [N];
   bit          m_in   [N];
   logic [8:0]  m_sch  [N][8];
   int          m_sn   [N];
   logic [7:0]  m_pay  [N][256];
   int          m_pl   [N];
   logic [8:0]  log_a[$];
   logic [8:0]  log_b[$];

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   task automatic sch_push(input int i, input logic [8:0] s);
      m_sch[i][m_sn[i]] = s;
      m_sn[i]++;
   endtask

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_sym[i] = K28_5; m_fcnt[i] = 16'd0; m_acnt[i] = 16'd0;
         m_in[i] = 1'b0; m_sn[i] = 0; m_pl[i] = 0;
      end
   endtask

   task automatic m_step(input int i, input bit crc_en);
      logic [15:0] c;
      if (m_sn[i] > 0) begin
         m_sym[i] = m_sch[i][0];
         for (int k = 0; k < 7; k++) m_sch[i][k] = m_sch[i][k+1];
         m_sn[i]--;
         if (m_sym[i] == K29_7) m_fcnt[i]++;
      end else if (m_in[i]) begin
         if (valid_i) begin
            m_sym[i] = {1'b0, data_i};
            if (m_pl[i] < 256) begin m_pay[i][m_pl[i]] = data_i; m_pl[i]++; end
            if (eop_i) begin
               c = 16'hFFFF;
               for (int k = 0; k < m_pl[i]; k++) c = crc_step(c, m_pay[i][k]);
               if (crc_en) begin
                  sch_push(i, {1'b0, c[15:8]});
                  sch_push(i, {1'b0, c[7:0]});
               end
               sch_push(i, K29_7);
               for (int k = 0; k < IFG_N; k++) sch_push(i, K28_5);
               m_in[i] = 1'b0;
            end
         end else begin
            m_sym[i] = K30_7;
            m_acnt[i]++;
            for (int k = 0; k < IFG_N; k++) sch_push(i, K28_5);
            m_in[i] = 1'b0;
         end
      end else if (enable && valid_i && sop_i) begin
         m_sym[i] = K27_7;
         m_in[i]  = 1'b1;
         m_pl[i]  = 0;
      end else begin
         m_sym[i] = K28_5;
      end
   endtask

   // Compare every cycle on the falling edge, then advance the model with the
   // inputs that the next rising edge will sample.
   always @(negedge clk) begin : cmp
      logic exp_rdy;
      if (rst) m_reset();
      for (int i = 0; i < N; i++) begin
         exp_rdy = (m_sn[i] == 0) && (m_in[i] || (valid_i && !sop_i));
         chk($sformatf("sym[%0d]", i),   o_sym[i],  m_sym[i]);
         chk($sformatf("busy[%0d]", i),  o_busy[i], (m_in[i] || m_sn[i] > 0));
         chk($sformatf("ready[%0d]", i), o_rdy[i],  exp_rdy);
         chk($sformatf("fcnt[%0d]", i),  o_fcnt[i], m_fcnt[i]);
         chk($sformatf("acnt[%0d]", i),  o_acnt[i], m_acnt[i]);
      end
      log_a.push_back(sym_a);
      log_b.push_back(sym_b);
      if (!rst) begin
         m_step(0, 1'b1);
         m_step(1, 1'b0);
      end
   end

   // ---------------- source ----------------
   typedef struct packed { logic v; logic s; logic e; logic [7:0] d; } word_t;
   word_t src_q[$];

   task automatic present();
      if (src_q.size() > 0) begin
         valid_i = src_q[0].v; sop_i = src_q[0].s; eop_i = src_q[0].e; data_i = src_q[0].d;
      end else begin
         valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; data_i = 8'h00;
      end
   endtask

   task automatic push_word(input logic s, input logic e, input logic [7:0] d);
      src_q.push_back({1'b1, s, e, d});
   endtask

   task automatic push_bubble();
      src_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});
   endtask

   // One clock: note acceptance before the edge, then advance the source
   task automatic tick();
      logic acc;
      @(negedge clk);
      acc = valid_i && ready_a;
      @(posedge clk);
      #1;
      if (src_q.size() > 0 && (!src_q[0].v || acc)) void'(src_q.pop_front());
      present();
   endtask

   task automatic drain(input string name, input int budget);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < budget) begin
         tick();
         n++;
         if (src_q.size() == 0 && !busy_a && !busy_b) quiet++;
         else quiet = 0;
      end
      chk({name, "_drained"}, (quiet >= 4), 1'b1);
   endtask

   task automatic chk_seq(input string name, input logic [8:0] q[$], input logic [8:0] e[$]);
      int base = -1;
      for (int k = 0; k < q.size(); k++) begin
         if (q[k] == K27_7) begin base = k; break; end
      end
      for (int k = 0; k < e.size(); k++) begin
         logic [8:0] act;
         act = 9'h000;
         if (base >= 0 && base + k < q.size()) act = q[base + k];
         chk($sformatf("%s[%0d]", name, k), act, e[k]);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] c;
      logic [7:0]  b;
      logic [8:0]  e[$];
      logic [15:0] f0;
      int          bad;

      // Pin the model CRC to the standard check value
      c = 16'hFFFF;
      for (int k = 0; k < 9; k++) begin b = 8'h31 + 8'(k); c = crc_step(c, b); end
      chk("model_crc_123456789", c, 16'h29B1);

      // Reset state
      present();
      @(negedge clk);
      #1;
      chk("reset_sym", sym_a, 9'h1BC);
      chk("reset_busy", busy_a, 1'b0);
      chk("reset_fcnt", fcnt_a, 16'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Idle line
      log_a.delete();
      repeat (20) tick();
      bad = 0;
      foreach (log_a[k]) if (log_a[k] != 9'h1BC) bad++;
      chk("idle_non_k285", bad, 0);
      chk("idle_ready", ready_a, 1'b0);
      chk("idle_busy", busy_a, 1'b0);

      // "123456789" with CRC
      log_a.delete();
      for (int k = 0; k < 9; k++) push_word(k == 0, k == 8, 8'h31 + 8'(k));
      present();
      drain("crc_frame", 100);
      e.delete();
      e.push_back(9'h1FB);
      for (int k = 0; k < 9; k++) e.push_back(9'h031 + 9'(k));
      e.push_back(9'h029); e.push_back(9'h0B1); e.push_back(9'h1FD); e.push_back(9'h1BC);
      chk_seq("crc_frame", log_a, e);
      chk("crc_frame_cnt", fcnt_a, 16'd1);

      // Back-to-back one-byte frames, CRC off instance
      log_b.delete();
      push_word(1'b1, 1'b1, 8'hA5);
      push_word(1'b1, 1'b1, 8'h5A);
      present();
      drain("b2b", 100);
      e.delete();
      e.push_back(9'h1FB); e.push_back(9'h0A5); e.push_back(9'h1FD); e.push_back(9'h1BC);
      e.push_back(9'h1BC); e.push_back(9'h1FB); e.push_back(9'h05A); e.push_back(9'h1FD);
      chk_seq("b2b", log_b, e);

      // Underrun after the third byte of six
      log_a.delete();
      f0 = fcnt_a;
      push_word(1'b1, 1'b0, 8'h10); push_word(1'b0, 1'b0, 8'h11); push_word(1'b0, 1'b0, 8'h12);
      push_bubble();
      push_word(1'b0, 1'b0, 8'h13); push_word(1'b0, 1'b0, 8'h14); push_word(1'b0, 1'b1, 8'h15);
      present();
      drain("underrun", 100);
      e.delete();
      e.push_back(9'h1FB); e.push_back(9'h010); e.push_back(9'h011); e.push_back(9'h012);
      e.push_back(9'h1FE);
      for (int k = 0; k < 5; k++) e.push_back(9'h1BC);
      chk_seq("underrun", log_a, e);
      chk("underrun_abort_cnt", acnt_a, 16'd1);
      chk("underrun_frame_cnt", fcnt_a, f0);

      // enable gating
      enable = 1'b0;
      f0 = fcnt_a;
      push_word(1'b1, 1'b0, 8'h20); push_word(1'b0, 1'b0, 8'h21); push_word(1'b0, 1'b1, 8'h22);
      present();
      repeat (5) tick();
      chk("disabled_ready", ready_a, 1'b0);
      chk("disabled_sym", sym_a, 9'h1BC);
      chk("disabled_busy", busy_a, 1'b0);
      enable = 1'b1;
      tick();
      chk("enable_sop", sym_a, 9'h1FB);
      tick();
      enable = 1'b0;
      drain("enable_drop", 100);
      chk("enable_drop_frame_done", fcnt_a, f0 + 16'd1);
      enable = 1'b1;

      // Randomized traffic with bubbles, stray words and enable toggling
      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(1, 8);
         if ($urandom_range(0, 4) == 0) push_word(1'b0, 1'b0, 8'($urandom));
         for (int k = 0; k < len; k++) begin
            push_word(k == 0, k == len - 1, 8'($urandom));
            if ($urandom_range(0, 11) == 0) push_bubble();
         end
      end
      present();
      for (int n = 0; n < 5000 && src_q.size() > 0; n++) begin
         enable = ($urandom_range(0, 4) != 0);
         tick();
      end
      enable = 1'b1;
      drain("random", 300);

      // Asynchronous reset while the CRC high byte is being sent
      push_word(1'b1, 1'b0, 8'hC3);
      push_word(1'b0, 1'b1, 8'h3C);
      present();
      repeat (3) tick();
      chk("pre_reset_last_byte", sym_a, 9'h03C);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_sym", sym_a, 9'h1BC);
      chk("async_rst_busy", busy_a, 1'b0);
      chk("async_rst_fcnt", fcnt_a, 16'd0);
      chk("async_rst_acnt", acnt_a, 16'd0);
      log_a.delete();
      tick();
      rst = 1'b0;
      repeat (6) tick();
      bad = 0;
      foreach (log_a[k]) if (log_a[k] == 9'h1FD) bad++;
      chk("async_rst_no_eop", bad, 0);
      chk("async_rst_fcnt_after", fcnt_a, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serdes_tx_framer.md
Name: serdes_tx_framer

Overview:
Frame-generation stage that sits directly upstream of the 8b/10b encoder in the USRP2 SERDES transmit path. It accepts a byte stream with sop/eop markers through a valid/ready handshake and drives one 9-bit {k,byte} symbol per clock to the encoder's datain. Its job is to wrap frames in K-code delimiters, append a CRC-16, and fill every non-frame cycle with K28.5 idles. Running disparity stays in the encoder and its disparity register; this block is disparity-agnostic.

Parameters:
MIN_IFG, 2, number of K28.5 idle symbols forced between an EOP or abort symbol and the next SOP; legal range 1..15.
CRC_EN, 1, when 1 the two CRC bytes are inserted before EOP; when 0 EOP follows the last data byte directly.

Ports:
clk  in  1  symbol clock, shared with the encoder.
rst  in  1  asynchronous, active-high reset.
enable  in  1  when 0, no new frame starts; a frame already in progress completes normally.
data_i  in  8  payload byte.
sop_i  in  1  marks the first byte of a frame; qualified by valid_i.
eop_i  in  1  marks the last byte of a frame; qualified by valid_i.
valid_i  in  1  upstream has a byte.
ready_o  out  1  byte accepted this cycle when valid_i & ready_o.
sym_o  out  9  registered {k, byte}; connects to encoder datain[8:0].
busy_o  out  1  high in any state other than IDLE.
frame_cnt_o  out  16  count of frames completed with EOP; wraps at 0xFFFF->0.
abort_cnt_o  out  16  count of frames aborted by underrun; wraps.

Behaviour:
- Symbol constants: IDLE K28.5 = 9'h1BC; SOP K27.7 = 9'h1FB; EOP K29.7 = 9'h1FD; ABORT K30.7 = 9'h1FE. Data and CRC bytes are {1'b0, byte}.
- sym_o is registered. The value computed in state S at edge n is visible after edge n+1. sym_o is never invalid: every cycle carries a symbol.
- On rst, asynchronously: state=IDLE, sym_o=9'h1BC, crc=16'hFFFF, ifg counter=0, frame_cnt_o=0, abort_cnt_o=0.
- ready_o is combinational from state and inputs:
  - 1 in DATA.
  - In IDLE, equal to valid_i & ~sop_i, so stray non-SOP words are flushed and discarded.
  - 0 in all other states.
- IDLE:
  - If enable & valid_i & sop_i: sym_o<=SOP, crc<=16'hFFFF, go to DATA. The SOP byte itself is not consumed here.
  - Otherwise sym_o<=IDLE.
- DATA:
  - If valid_i: sym_o<={0,data_i}, crc<=crc_next(crc,data_i). sop_i is ignored in DATA.
  - If valid_i & eop_i: go to CRC_HI when CRC_EN=1, else to EOP.
  - If ~valid_i (underrun): sym_o<=ABORT, abort_cnt_o++, go to IFG with counter=0.
- CRC_HI: sym_o<={0,crc[15:8]}, go to CRC_LO. The crc register already includes the final data byte.
- CRC_LO: sym_o<={0,crc[7:0]}, go to EOP.
- EOP: sym_o<=EOP, frame_cnt_o++, go to IFG with counter=0.
- IFG: sym_o<=IDLE, counter++. When counter==MIN_IFG-1, go to IDLE.
- Resulting guarantee: exactly MIN_IFG idle symbols appear between EOP/ABORT and the next SOP when the next frame is already pending. A one-byte frame is legal (sop and eop on the same word); an empty frame cannot be generated.
- CRC definition: CRC-16-CCITT, poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR, computed over payload bytes only.
- enable falling mid-frame has no effect until the frame returns to IDLE.
- rst asserted mid-frame truncates the output immediately to IDLE symbols. No EOP or ABORT symbol is emitted and no counter is incremented.

Decomposition:
- Shared package serdes_pkg holds:
  - K-code constants K28_5, K27_7, K29_7, K30_7 as 9-bit values.
  - The state enum {IDLE, DATA, CRC_HI, CRC_LO, EOP, IFG}.
  - CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF.
- One sub-module, crc16_ccitt_8: a combinational byte-wide next-CRC function taking (crc_in[15:0], data[7:0]) and producing crc_out[15:0].
- The FSM, counters and output register live in serdes_tx_framer.

Test Plan:
- Reset then 20 cycles with valid_i=0 -> sym_o=9'h1BC every cycle; ready_o=0, busy_o=0.
- Frame "123456789" (0x31..0x39), valid_i held high, CRC_EN=1 -> sym_o sequence is 1FB, 031..039, 029, 0B1, 1FD, then 1BC; frame_cnt_o=1.
- Two back-to-back 1-byte frames 0xA5, 0x5A, MIN_IFG=2, CRC_EN=0 -> 1FB, 0A5, 1FD, 1BC, 1BC, 1FB, 05A, 1FD.
- Underrun: valid_i drops after the 3rd byte of a 6-byte frame -> sym_o is 1FB, b0, b1, b2, 1FE, then 2 idles; abort_cnt_o=1, frame_cnt_o unchanged. Remaining bytes with sop_i=0 are flushed in IDLE while sym_o stays 1BC.
- enable=0 with sop pending -> idles continue and ready_o=0. Raising enable -> SOP appears 1 cycle later. enable dropped mid-frame -> the frame completes with CRC and EOP.
- rst pulsed while in CRC_HI -> sym_o=9'h1BC immediately (asynchronous), state IDLE, counters 0, no 1FD emitted.
